// File: rtl/ntt_addr_gen.sv
// Read-address generator for an in-place radix-2 NTT over two parity-interleaved banks.
// Walks LOGN stages of N/2 butterflies, with GAP bubbles between stages for writeback drain.
module ntt_addr_gen #(
   parameter int LOGN = 8,
   parameter int GAP  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stall,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic [LOGN-2:0]         addr_a0,
   output logic [LOGN-2:0]         addr_a1,
   output logic                    sel_a,
   output logic [$clog2(LOGN)-1:0] stage,
   output logic [LOGN-2:0]         tw_idx
);
   localparam int SW = $clog2(LOGN);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [LOGN-2:0] B_LAST = {(LOGN-1){1'b1}};
   localparam logic [SW-1:0]   S_LAST = SW'(LOGN-1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [LOGN-2:0] b, b_nxt;
   logic [SW-1:0]   s, s_nxt;
   logic [GW-1:0]   g, g_nxt;

   always_comb begin
      state_nxt = state;
      b_nxt     = b;
      s_nxt     = s;
      g_nxt     = g;
      case (state)
         S_IDLE: if (start) begin
            state_nxt = S_RUN;
            b_nxt     = '0;
            s_nxt     = '0;
         end
         S_RUN: if (!stall) begin
            if (b == B_LAST) begin
               b_nxt = '0;
               if (s == S_LAST) state_nxt = S_DONE;
               else begin
                  s_nxt     = s + 1'b1;
                  g_nxt     = '0;
                  state_nxt = (GAP == 0) ? S_RUN : S_GAP;
               end
            end else b_nxt = b + 1'b1;
         end
         S_GAP: if (!stall) begin
            if (int'(g) >= GAP - 1) state_nxt = S_RUN;
            else g_nxt = g + 1'b1;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            s_nxt     = '0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Butterfly indices for the upcoming cycle; the outputs register these directly.
   int              p;
   logic [LOGN-1:0] bx, m, lo, i0;
   logic [LOGN-2:0] ad0, ad1, a0_nxt, a1_nxt, tw_nxt;
   logic            sel_nxt, run_nxt, busy_nxt;

   always_comb begin
      p        = LOGN - 1 - int'(s_nxt);
      bx       = {1'b0, b_nxt};
      m        = LOGN'(1) << p;
      lo       = m - LOGN'(1);
      i0       = ((bx & ~lo) << 1) | (bx & lo);
      ad0      = i0[LOGN-1:1];
      // i1 = i0 + m differs only in bit p; for p = 0 both share one address
      ad1      = ad0 | m[LOGN-1:1];
      sel_nxt  = ^i0;
      a0_nxt   = sel_nxt ? ad1 : ad0;
      a1_nxt   = sel_nxt ? ad0 : ad1;
      tw_nxt   = (b_nxt & lo[LOGN-2:0]) << s_nxt;
      run_nxt  = (state_nxt == S_RUN);
      busy_nxt = run_nxt || (state_nxt == S_GAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         b       <= '0;
         s       <= '0;
         g       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         valid   <= 1'b0;
         sel_a   <= 1'b0;
         addr_a0 <= '0;
         addr_a1 <= '0;
         stage   <= '0;
         tw_idx  <= '0;
      end else begin
         state   <= state_nxt;
         b       <= b_nxt;
         s       <= s_nxt;
         g       <= g_nxt;
         busy    <= busy_nxt;
         done    <= (state_nxt == S_DONE);
         valid   <= run_nxt;
         sel_a   <= run_nxt & sel_nxt;
         addr_a0 <= run_nxt ? a0_nxt : '0;
         addr_a1 <= run_nxt ? a1_nxt : '0;
         stage   <= busy_nxt ? s_nxt : '0;
         tw_idx  <= run_nxt ? tw_nxt : '0;
      end
   end
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Randomized bench for ntt_addr_gen: per-cycle comparison against a list of expected
// butterflies built from plain index arithmetic, plus per-stage bank-coverage scoreboard.
module tb_ntt_addr_gen;
   localparam int LOGN = 8;
   localparam int GAP  = 4;
   localparam int H    = 128;

   logic       clk = 1'b0, rst, start, stall;
   logic       busy, done, valid, sel_a;
   logic [6:0] addr_a0, addr_a1, tw_idx;
   logic [2:0] stage;

   ntt_addr_gen #(.LOGN(LOGN), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .busy(busy), .done(done), .valid(valid),
      .addr_a0(addr_a0), .addr_a1(addr_a1), .sel_a(sel_a),
      .stage(stage), .tw_idx(tw_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy, done, valid, sel;
      logic [2:0] s;
      logic [6:0] a0, a1, tw, b;
   } ent_t;

   ent_t cur;
   ent_t q[$];
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, first_v, stalls_run, vcount;
   int   cnt0[LOGN][H], cnt1[LOGN][H];

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
   endtask

   function automatic int unsigned obs_pack(input logic show_stage);
      return {busy, done, valid, sel_a, (show_stage ? stage : 3'd0), addr_a0, addr_a1, tw_idx};
   endfunction

   function automatic int unsigned exp_pack(input ent_t e);
      return {e.busy, e.done, e.valid, e.sel, (e.valid ? e.s : 3'd0), e.a0, e.a1, e.tw};
   endfunction

   // Expected sequence of one whole transform, straight from the index rules.
   task automatic build();
      ent_t e;
      q.delete();
      for (int s = 0; s < LOGN; s++) begin
         int m = 1 << (LOGN - 1 - s);
         for (int b = 0; b < H; b++) begin
            int i0 = (b / m) * 2 * m + b % m;
            int i1 = i0 + m;
            int bk = $countones(i0) & 1;
            e = '0;
            e.busy = 1; e.valid = 1; e.s = 3'(s); e.b = 7'(b);
            e.sel = bk[0];
            e.a0  = 7'(bk ? i1 / 2 : i0 / 2);
            e.a1  = 7'(bk ? i0 / 2 : i1 / 2);
            e.tw  = 7'(((b % m) << s) % H);
            q.push_back(e);
         end
         if (s < LOGN - 1)
            for (int k = 0; k < GAP; k++) begin
               e = '0; e.busy = 1; e.s = 3'(s + 1);
               q.push_back(e);
            end
      end
      e = '0; e.done = 1;
      q.push_back(e);
      first_v = -1; stalls_run = 0; vcount = 0;
      for (int s = 0; s < LOGN; s++)
         for (int a = 0; a < H; a++) begin cnt0[s][a] = 0; cnt1[s][a] = 0; end
   endtask

   // Called at a negedge: check the visible cycle, drive inputs for the next edge, advance model.
   task automatic cycle(input logic st, input logic sl);
      logic held;
      int   bad;
      check("outputs", obs_pack(cur.valid), exp_pack(cur));
      held = cur.busy && sl;
      if (cur.valid && first_v < 0) first_v = cyc;
      if (valid && !held) begin
         cnt0[stage][addr_a0]++;
         cnt1[stage][addr_a1]++;
         vcount++;
      end
      if (cur.done) begin
         bad = 0;
         for (int s = 0; s < LOGN; s++)
            for (int a = 0; a < H; a++)
               if (cnt0[s][a] != 1 || cnt1[s][a] != 1) bad++;
         check("conflict_free", bad, 0);
         check("valid_count", vcount, LOGN * H);
         check("latency", cyc - first_v, LOGN * H + (LOGN - 1) * GAP + stalls_run);
      end
      start = st;
      stall = sl;
      if (held) stalls_run++;
      else if (q.size() > 0) cur = q.pop_front();
      else if (!cur.busy && !cur.done && st) begin build(); cur = q.pop_front(); end
      else cur = '0;
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int mode);
      int   n = 0, hold = 0;
      logic sl;
      cycle(1'b1, 1'b0);
      while (!cur.done && n < 5000) begin
         sl = 1'b0;
         if (mode == 1 && cur.valid && cur.s == 3'd2 && cur.b == 7'd17 && hold < 3) begin
            sl = 1'b1; hold++;
         end
         if (mode == 2) sl = ($urandom_range(0, 5) == 0);
         cycle(mode == 0 && (n % 257 == 3), sl);
         n++;
      end
      if (!cur.done) check("timeout", 1, 0);
      cycle(1'b1, 1'b0);          // start coincident with done
      repeat (3) cycle(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; cur = '0;
      #1 check("reset_outs", obs_pack(1'b1), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (2) cycle(1'b0, $urandom_range(0, 1) == 1);

      run(0);
      run(1);
      run(2);

      // Abort mid-transform, then a fresh transform must restart at s=0, b=0.
      cycle(1'b1, 1'b0);
      repeat (400) cycle(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 check("rst_async", obs_pack(1'b1), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; cur = '0; q.delete();
      repeat (3) cycle(1'b0, 1'b0);
      run(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
